ndro_bank: RTL
==============

NDRO_BANK -- requirements
Module: ndro_bank

Interface
REQ-001 The block SHALL expose these parameters:
- N_CH, default 4, number of independent NDRO channels (1..32).
- SIG_OUT_DELAY, default 3, clock cycles from a sig pulse to its out pulse (>=1).
- OFF_DOUT_DELAY, default 2, clock cycles from an off pulse to its dout pulse (>=1).
- ON_GUARD, default 2, cycles after an on pulse during which sig/off is a timing violation (>=0).
- VCNT_W, default 8, violation counter width.
REQ-002 The block SHALL expose these ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- on  in  N_CH  one-cycle set pulses, per channel
- off  in  N_CH  one-cycle clear-and-read pulses
- sig  in  N_CH  one-cycle non-destructive read pulses
- clr_viol  in  1  synchronous clear of viol_count
- out  out  N_CH  read-result pulse from sig
- out_x  out  N_CH  out result is unknown
- dout  out  N_CH  read-result pulse from off
- dout_x  out  N_CH  dout result is unknown
- viol  out  N_CH  one-cycle timing-violation flag
- viol_count  out  VCNT_W  saturating violation total

Function
REQ-003 Each channel SHALL hold a state of ZERO, ONE or UNK, plus a guard down-counter loaded with ON_GUARD on every on pulse and decremented to 0 on each later cycle.
REQ-004 A channel SHALL be "contested" in a cycle when its guard counter is non-zero or its on input is high in that cycle.
REQ-005 Next state: on&off -> UNK; off without on -> ZERO; on&sig -> UNK; on alone -> ONE; sig alone while guard non-zero -> UNK; otherwise unchanged.
REQ-006 An on pulse during an active guard SHALL reload the guard without a violation.
REQ-007 A sig pulse in cycle t SHALL produce exactly one pulse SIG_OUT_DELAY cycles later:
- uncontested, state ONE -> out=1, out_x=0
- uncontested, state ZERO -> out=0, out_x=0
- state UNK or contested -> out=0, out_x=1
REQ-008 The result SHALL always use the state held before cycle t's events, and sig SHALL NOT change the state except as in REQ-005.
REQ-009 An off pulse in cycle t SHALL produce dout/dout_x OFF_DOUT_DELAY cycles later with the same encoding as REQ-007, then leave the state per REQ-005.
REQ-010 sig and off in the same cycle SHALL both report the pre-event state on their own outputs.
REQ-011 out, out_x, dout and dout_x SHALL be one-cycle pulses.
REQ-012 Back-to-back pulses on consecutive cycles SHALL each produce an independent result (fully pipelined delay lines, no back-pressure).
REQ-013 viol[ch] SHALL pulse in cycle t+1 when channel ch sees a contested sig or contested off in cycle t.
REQ-014 viol_count SHALL add popcount(viol) each cycle and saturate at 2^VCNT_W-1.
REQ-015 clr_viol SHALL zero viol_count, and the clear SHALL take priority over a same-cycle increment.
REQ-016 Channels SHALL be fully independent, except that they share viol_count.

Reset
REQ-017 While rst is high (asynchronously), all outputs SHALL be 0, every state ZERO, every guard 0, all delay pipelines empty and viol_count 0.
REQ-018 Asserting rst mid-operation SHALL discard all pending out/dout pulses; no pulse from pre-reset events may appear after release.
REQ-019 Events SHALL be accepted from the first rising clk edge after rst deasserts.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Defaults; ch0: on@0, sig@5 -> out[0]=1, out_x=0 at cycle 8; state stays ONE; sig@9 -> out[0]=1 at 12.
- ch1: on@0, sig@1 (guard active) -> viol[1]@2, out_x[1]=1@4, state UNK; later uncontested sig@10 -> out_x[1]=1@13.
- ch2: on@0, off@6 -> dout[2]=1@8; sig@9 -> out[2]=0, out_x=0@12; on&off same cycle -> viol, dout_x=1, state UNK.
- All 4 channels: contested sig every cycle for 100 cycles with VCNT_W=8 -> viol_count saturates at 255; clr_viol together with viol -> count 0.
- Pending: sig@0, off@0, rst asserted mid-cycle 1 -> no out/dout pulses afterwards; all outputs 0 during reset.
- ON_GUARD=0: on@0 then sig@1 -> no violation, out=1@4; on&sig same cycle still flags viol.

Source files
------------

// File: rtl/ndro_bank.sv
// Bank of N_CH non-destructive-readout (NDRO) cells with per-channel timing guards.
// Latency: sig->out/out_x SIG_OUT_DELAY cycles, off->dout/dout_x OFF_DOUT_DELAY cycles, viol 1 cycle.
// Backpressure: none; every pulse enters a free-running delay line, one result per input pulse.
//
// Ports:
//   clk, rst (async, active-high)
//   on/off/sig       per-channel set / clear-and-read / non-destructive read pulses
//   clr_viol         synchronous clear of viol_count (wins over a same-cycle increment)
//   out/out_x        sig read result (out_x = result unknown)
//   dout/dout_x      off read result (dout_x = result unknown)
//   viol             per-channel timing-violation pulse
//   viol_count       saturating total of viol pulses
module ndro_bank #(
    parameter int N_CH           = 4,
    parameter int SIG_OUT_DELAY  = 3,
    parameter int OFF_DOUT_DELAY = 2,
    parameter int ON_GUARD       = 2,
    parameter int VCNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   on,
    input  logic [N_CH-1:0]   off,
    input  logic [N_CH-1:0]   sig,
    input  logic              clr_viol,
    output logic [N_CH-1:0]   out,
    output logic [N_CH-1:0]   out_x,
    output logic [N_CH-1:0]   dout,
    output logic [N_CH-1:0]   dout_x,
    output logic [N_CH-1:0]   viol,
    output logic [VCNT_W-1:0] viol_count
);

    // A zero-length guard still needs a 1-bit counter that simply stays 0.
    localparam int GW    = (ON_GUARD > 0) ? $clog2(ON_GUARD + 1) : 1;
    localparam int SUM_W = VCNT_W + 6;

    typedef enum logic [1:0] {
        ST_ZERO = 2'd0,
        ST_ONE  = 2'd1,
        ST_UNK  = 2'd2
    } ndro_state_e;

    ndro_state_e       state_q [N_CH];
    ndro_state_e       state_d [N_CH];
    logic [GW-1:0]     guard_q [N_CH];
    logic [GW-1:0]     guard_d [N_CH];

    logic [N_CH-1:0]   contested;
    logic [N_CH-1:0]   rd_one;
    logic [N_CH-1:0]   rd_unk;
    logic [N_CH-1:0]   viol_d;

    logic [N_CH-1:0]   out_pipe_q   [SIG_OUT_DELAY];
    logic [N_CH-1:0]   outx_pipe_q  [SIG_OUT_DELAY];
    logic [N_CH-1:0]   dout_pipe_q  [OFF_DOUT_DELAY];
    logic [N_CH-1:0]   doutx_pipe_q [OFF_DOUT_DELAY];
    logic [N_CH-1:0]   viol_q;

    logic [VCNT_W-1:0] vcnt_q;
    logic [VCNT_W-1:0] vcnt_d;
    logic [5:0]        viol_pop;
    logic [SUM_W-1:0]  vsum;

    // Per-channel read classification and next state. Reads always see the
    // state held before this cycle's events.
    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            contested[ch] = (guard_q[ch] != '0) || on[ch];
            rd_unk[ch]    = (state_q[ch] == ST_UNK) || contested[ch];
            rd_one[ch]    = (state_q[ch] == ST_ONE) && !contested[ch];

            state_d[ch] = state_q[ch];
            if (on[ch] && off[ch]) begin
                state_d[ch] = ST_UNK;
            end else if (off[ch]) begin
                state_d[ch] = ST_ZERO;
            end else if (on[ch] && sig[ch]) begin
                state_d[ch] = ST_UNK;
            end else if (on[ch]) begin
                state_d[ch] = ST_ONE;
            end else if (sig[ch] && (guard_q[ch] != '0)) begin
                state_d[ch] = ST_UNK;
            end

            // Re-arming during an active guard simply reloads it.
            if (on[ch]) begin
                guard_d[ch] = GW'(ON_GUARD);
            end else if (guard_q[ch] != '0) begin
                guard_d[ch] = guard_q[ch] - GW'(1);
            end else begin
                guard_d[ch] = guard_q[ch];
            end
        end
        viol_d = (sig | off) & contested;
    end

    // Violation total: add this cycle's visible viol pulses, saturate, clear wins.
    always_comb begin
        viol_pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            viol_pop = viol_pop + 6'(viol_q[i]);
        end
        vsum = SUM_W'(vcnt_q) + SUM_W'(viol_pop);
        if (clr_viol) begin
            vcnt_d = '0;
        end else if (vsum > SUM_W'({VCNT_W{1'b1}})) begin
            vcnt_d = '1;
        end else begin
            vcnt_d = vsum[VCNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                state_q[ch] <= ST_ZERO;
                guard_q[ch] <= '0;
            end
            for (int i = 0; i < SIG_OUT_DELAY; i++) begin
                out_pipe_q[i]  <= '0;
                outx_pipe_q[i] <= '0;
            end
            for (int i = 0; i < OFF_DOUT_DELAY; i++) begin
                dout_pipe_q[i]  <= '0;
                doutx_pipe_q[i] <= '0;
            end
            viol_q <= '0;
            vcnt_q <= '0;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                guard_q[ch] <= guard_d[ch];
            end
            out_pipe_q[0]  <= sig & rd_one;
            outx_pipe_q[0] <= sig & rd_unk;
            for (int i = 1; i < SIG_OUT_DELAY; i++) begin
                out_pipe_q[i]  <= out_pipe_q[i-1];
                outx_pipe_q[i] <= outx_pipe_q[i-1];
            end
            dout_pipe_q[0]  <= off & rd_one;
            doutx_pipe_q[0] <= off & rd_unk;
            for (int i = 1; i < OFF_DOUT_DELAY; i++) begin
                dout_pipe_q[i]  <= dout_pipe_q[i-1];
                doutx_pipe_q[i] <= doutx_pipe_q[i-1];
            end
            viol_q <= viol_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign out        = out_pipe_q[SIG_OUT_DELAY-1];
    assign out_x      = outx_pipe_q[SIG_OUT_DELAY-1];
    assign dout       = dout_pipe_q[OFF_DOUT_DELAY-1];
    assign dout_x     = doutx_pipe_q[OFF_DOUT_DELAY-1];
    assign viol       = viol_q;
    assign viol_count = vcnt_q;

endmodule
